// File: rtl/uart_rx_ctrl_pkg.sv
// Shared constants and FSM state encoding for the UART receive controller.
package uart_pkg;
  localparam int UART_DATA_BITS = 8;
  localparam int UART_MIN_DIV   = 4;

  typedef logic [2:0] state_t;
  localparam state_t HUNT    = 3'd0;
  localparam state_t START   = 3'd1;
  localparam state_t DATA    = 3'd2;
  localparam state_t STOP    = 3'd3;
  localparam state_t CAPTURE = 3'd4;
endpackage

// File: rtl/uart_rx_fifo.sv
// Small circular receive FIFO; head entry is driven straight from the storage flops.
module uart_rx_fifo #(
  parameter  int WIDTH = 9,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);
  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wr_ptr, rd_ptr;
  logic                        do_push, do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end
endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: line sync, mid-bit baud ticks, frame FSM and receive FIFO.
// Define UART_RX_FERR_DROP_EN to discard frames with a bad stop bit instead of flagging them.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter  int DIV_W      = 16,
  parameter  int FIFO_DEPTH = 4,
  localparam int LW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [DIV_W-1:0]          baud_div,
  input  logic                      rxd,
  output logic                      rx_enable_clk,
  output logic                      rx_valid,
  output logic                      rx_in,
  input  logic [UART_DATA_BITS-1:0] rx_data,
  output logic [UART_DATA_BITS-1:0] m_data,
  output logic                      m_ferr,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic                      overrun,
  input  logic                      overrun_clr,
  output logic                      busy,
  output logic [LW-1:0]             fifo_level
);
`ifdef UART_RX_FERR_DROP_EN
  localparam int FW = UART_DATA_BITS;
`else
  localparam int FW = UART_DATA_BITS + 1;
`endif

  logic             sync1, line_s, line_p;
  state_t           state;
  logic [DIV_W-1:0] div_lat, cnt, div_in;
  logic [2:0]       bitcnt;
  logic             ferr_r, running, tick;
  logic             push, pop, full, empty;
  logic [FW-1:0]    fifo_din, fifo_dout;

  assign div_in  = (baud_div < DIV_W'(UART_MIN_DIV)) ? DIV_W'(UART_MIN_DIV) : baud_div;
  assign running = (state == START) || (state == DATA) || (state == STOP);
  assign tick    = running && (cnt == '0);

  assign rx_enable_clk = tick;
  assign rx_valid      = (state == START);
  assign rx_in         = line_s;
  assign busy          = (state != HUNT);

  // Idle-high reset keeps a spurious falling edge from appearing after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b1;
      line_s <= 1'b1;
      line_p <= 1'b1;
    end else begin
      sync1  <= rxd;
      line_s <= sync1;
      line_p <= line_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= HUNT;
      div_lat <= DIV_W'(UART_MIN_DIV);
      cnt     <= '0;
      bitcnt  <= '0;
      ferr_r  <= 1'b0;
    end else begin
      if (running) cnt <= tick ? div_lat - DIV_W'(1) : cnt - DIV_W'(1);
      case (state)
        HUNT: if (en && line_p && !line_s) begin
          // Half-period preload puts every following tick at mid-bit.
          state   <= START;
          div_lat <= div_in;
          cnt     <= div_in >> 1;
        end
        START: if (tick) begin
          if (!line_s) begin
            state  <= DATA;
            bitcnt <= '0;
          end else begin
            state <= HUNT;
          end
        end
        DATA: if (tick) begin
          bitcnt <= bitcnt + 3'd1;
          if (bitcnt == 3'(UART_DATA_BITS - 1)) state <= STOP;
        end
        STOP: if (tick) begin
          ferr_r <= ~line_s;
          state  <= CAPTURE;
        end
        CAPTURE: state <= HUNT;
        default: state <= HUNT;
      endcase
    end
  end

`ifdef UART_RX_FERR_DROP_EN
  assign push     = (state == CAPTURE) && !ferr_r;
  assign fifo_din = rx_data;
  assign m_data   = fifo_dout;
  assign m_ferr   = 1'b0;
`else
  assign push     = (state == CAPTURE);
  assign fifo_din = {ferr_r, rx_data};
  assign {m_ferr, m_data} = fifo_dout;
`endif

  assign m_valid = !empty;
  assign pop     = m_valid && m_ready;

  uart_rx_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     overrun <= 1'b0;
    else if (push && full && !pop)  overrun <= 1'b1;
    else if (overrun_clr)           overrun <= 1'b0;
  end
endmodule
